// File: rtl/div_request_scheduler.sv
// Round-robin front end sharing one restoring divider among NUM_REQ clients, with a
// divide-by-zero bypass, bounded divider handshakes and a tagged response port.
module div_request_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_dividend,
    input  logic [NUM_REQ*WIDTH-1:0]   req_divisor,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]           rsp_quotient,
    output logic [WIDTH-1:0]           rsp_remainder,
    output logic [1:0]                 rsp_status,
    output logic                       div_st,
    output logic [WIDTH-1:0]           div_qbus,
    output logic [WIDTH-1:0]           div_mbus,
    input  logic                       div_ready,
    input  logic [WIDTH-1:0]           div_abus,
    input  logic [WIDTH-1:0]           div_qres
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int IDX_W = ID_W + 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [IDX_W-1:0] NREQ_X  = IDX_W'(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_DBZ = 2'b01;
    localparam logic [1:0] ST_TMO = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE      = 3'd1,
        S_WAIT_START = 3'd2,
        S_WAIT_DONE  = 3'd3,
        S_RESPOND    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  qbus_q, qbus_d;
    logic [WIDTH-1:0]  mbus_q, mbus_d;
    logic              div_st_q, div_st_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]  quot_q, quot_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [1:0]        status_q, status_d;
    logic [ID_W-1:0]   winner_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [WIDTH-1:0]  dividend_s;
    logic [WIDTH-1:0]  divisor_s;

    // Round-robin search for the first valid requester at or above the pointer.
    always_comb begin
        logic [IDX_W-1:0] sum_v;
        logic [IDX_W-1:0] wrap_v;
        logic [ID_W-1:0]  idx_v;
        logic             hit_v;
        winner_s = '0;
        hit_v    = 1'b0;
        sum_v    = '0;
        wrap_v   = '0;
        idx_v    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_v = {1'b0, ptr_q} + IDX_W'(k);
            if (sum_v >= NREQ_X) begin
                wrap_v = sum_v - NREQ_X;
            end else begin
                wrap_v = sum_v;
            end
            idx_v = wrap_v[ID_W-1:0];
            if (!hit_v && req_valid[idx_v]) begin
                winner_s = idx_v;
                hit_v    = 1'b1;
            end else begin
                hit_v = hit_v;
            end
        end
    end

    assign dividend_s = req_dividend[winner_s*WIDTH +: WIDTH];
    assign divisor_s  = req_divisor[winner_s*WIDTH +: WIDTH];

    // Job sequencing: accept, start pulse, handshake waits with timeout, response.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        cnt_d    = cnt_q;
        qbus_d   = qbus_q;
        mbus_d   = mbus_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        status_d = status_q;
        grant_s  = '0;
        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    grant_s[winner_s] = 1'b1;
                    id_d              = winner_s;
                    if (divisor_s == '0) begin
                        quot_d   = '1;
                        rem_d    = dividend_s;
                        status_d = ST_DBZ;
                        state_d  = S_RESPOND;
                    end else begin
                        qbus_d  = dividend_s;
                        mbus_d  = divisor_s;
                        state_d = S_ISSUE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (!div_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == CNT_MAX) begin
                    quot_d   = '0;
                    rem_d    = '0;
                    status_d = ST_TMO;
                    state_d  = S_RESPOND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (div_ready) begin
                    quot_d   = div_qres;
                    rem_d    = div_abus;
                    status_d = ST_OK;
                    state_d  = S_RESPOND;
                end else if (cnt_q == CNT_MAX) begin
                    quot_d   = '0;
                    rem_d    = '0;
                    status_d = ST_TMO;
                    state_d  = S_RESPOND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESPOND: begin
                if (int'(id_q) == NUM_REQ - 1) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = id_q + ID_W'(1);
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Strobes are registered from the state being entered so they line up with it.
        rsp_valid_d = (state_d == S_RESPOND);
        div_st_d    = (state_d == S_ISSUE);
        if (state_d == S_RESPOND) begin
            rsp_id_d = id_d;
        end else begin
            rsp_id_d = rsp_id_q;
        end
    end

    // State and output registers; reset drops any job in flight without a response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            qbus_q      <= '0;
            mbus_q      <= '0;
            div_st_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            status_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            qbus_q      <= qbus_d;
            mbus_q      <= mbus_d;
            div_st_q    <= div_st_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            status_q    <= status_d;
        end
    end

    assign req_ready     = grant_s & {NUM_REQ{rst}};
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_quotient  = quot_q;
    assign rsp_remainder = rem_q;
    assign rsp_status    = status_q;
    assign div_st        = div_st_q;
    assign div_qbus      = qbus_q;
    assign div_mbus      = mbus_q;

endmodule

// File: tb/tb_div_request_scheduler.sv
// Directed bench for div_request_scheduler with a behavioural restoring-divider stand-in.
module tb_div_request_scheduler;
    localparam int NR  = 4;
    localparam int W   = 8;
    localparam int TO  = 16;
    localparam int LAT = 6;

    logic            clk, rst;
    logic [NR-1:0]   req_valid, req_ready;
    logic [NR*W-1:0] req_dividend, req_divisor;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [W-1:0]    rsp_quotient, rsp_remainder;
    logic [1:0]      rsp_status;
    logic            div_st, div_ready;
    logic [W-1:0]    div_qbus, div_mbus, div_abus, div_qres;

    logic            stuck, rdy_m;
    logic [W-1:0]    a_m, m_m;
    int              lat_m;
    int              n_cmp, n_bad, st_total;
    logic [NR-1:0]   g;

    typedef struct {
        int id; int a; int b; int q; int r; int st; int lat;
    } vec_t;
    vec_t vecs[9];

    div_request_scheduler #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_status(rsp_status),
        .div_st(div_st), .div_qbus(div_qbus), .div_mbus(div_mbus),
        .div_ready(div_ready), .div_abus(div_abus), .div_qres(div_qres)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider stand-in: drops ready after st, answers LAT cycles later.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_m <= 1'b1; lat_m <= 0; a_m <= '0; m_m <= '0;
            div_qres <= '0; div_abus <= '0;
        end else if (div_st) begin
            rdy_m <= 1'b0; lat_m <= LAT; a_m <= div_qbus; m_m <= div_mbus;
        end else if (!rdy_m) begin
            if (lat_m <= 1) begin
                rdy_m <= 1'b1; div_qres <= a_m / m_m; div_abus <= a_m % m_m;
            end else begin
                lat_m <= lat_m - 1;
            end
        end
    end
    assign div_ready = stuck | rdy_m;

    always @(negedge clk) if (div_st) st_total++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_req_ready"}, 32'(req_ready), 0);
        chk({name, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({name, "_rsp_id"}, 32'(rsp_id), 0);
        chk({name, "_rsp_q"}, 32'(rsp_quotient), 0);
        chk({name, "_rsp_r"}, 32'(rsp_remainder), 0);
        chk({name, "_rsp_status"}, 32'(rsp_status), 0);
        chk({name, "_div_st"}, 32'(div_st), 0);
        chk({name, "_div_qbus"}, 32'(div_qbus), 0);
        chk({name, "_div_mbus"}, 32'(div_mbus), 0);
    endtask

    // Present one request and hold it until granted; returns just after the transfer edge.
    task automatic accept(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string name);
        bit got;
        got = 1'b0;
        @(negedge clk);
        req_dividend[id*W +: W] = a;
        req_divisor[id*W +: W]  = b;
        req_valid[id]           = 1'b1;
        for (int c = 0; c < 100 && !got; c++) begin
            #1;
            if (req_ready[id]) got = 1'b1;
            else @(negedge clk);
        end
        chk({name, "_accept"}, 32'(got), 1);
        if (got) begin
            @(posedge clk);
            #1;
        end
        req_valid[id] = 1'b0;
    endtask

    // n = cycle offset of rsp_valid relative to the acceptance cycle.
    task automatic wait_rsp(output int n, input string name);
        n = 1;
        while (!rsp_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_rsp_seen"}, 32'(rsp_valid), 1);
    endtask

    task automatic run_job(input int id, input int a, input int b, input int q, input int r,
                           input int st, input int lat, input string name);
        int n;
        int s0;
        s0 = st_total;
        accept(id, W'(a), W'(b), name);
        wait_rsp(n, name);
        chk({name, "_latency"}, 32'(n), 32'(lat));
        chk({name, "_id"}, 32'(rsp_id), 32'(id));
        chk({name, "_q"}, 32'(rsp_quotient), 32'(q));
        chk({name, "_r"}, 32'(rsp_remainder), 32'(r));
        chk({name, "_status"}, 32'(rsp_status), 32'(st));
        chk({name, "_st_pulses"}, 32'(st_total - s0), (st == 1) ? 32'd0 : 32'd1);
        if (st == 0) begin
            chk({name, "_qbus"}, 32'(div_qbus), 32'(a));
            chk({name, "_mbus"}, 32'(div_mbus), 32'(b));
        end
        @(posedge clk);
        #1;
        chk({name, "_rsp_one_cycle"}, 32'(rsp_valid), 0);
        chk({name, "_q_hold"}, 32'(rsp_quotient), 32'(q));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int got;
        int cnt;
        int m_id[4];
        int m_q[4];
        int m_r[4];
        rst = 1'b0; stuck = 1'b0; req_valid = '0; req_dividend = '0; req_divisor = '0;
        n_cmp = 0; n_bad = 0;
        vecs[0] = '{0, 219,  12,  18,   3, 0, 9};
        vecs[1] = '{2, 'h37,  0, 'hFF, 'h37, 1, 1};
        vecs[2] = '{3, 100,   7,  14,   2, 0, 9};
        vecs[3] = '{1, 255,   1, 255,   0, 0, 9};
        vecs[4] = '{3,   5, 200,   0,   5, 0, 9};
        vecs[5] = '{0,   0,   9,   0,   0, 0, 9};
        vecs[6] = '{3,   0,   0, 'hFF,   0, 1, 1};
        vecs[7] = '{2, 215,  19,  11,   6, 0, 9};
        vecs[8] = '{1, 255, 255,   1,   0, 0, 9};
        m_id = '{0, 1, 2, 3};
        m_q  = '{18, 6, 11, 14};
        m_r  = '{3, 20, 6, 2};

        #2;
        chk_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_job(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                    vecs[i].st, vecs[i].lat, $sformatf("v%0d", i));
        end

        // Reset mid-job with all requesters valid, then serve all four in order.
        @(negedge clk);
        req_dividend = {8'd100, 8'd215, 8'd188, 8'd219};
        req_divisor  = {8'd7, 8'd19, 8'd28, 8'd12};
        req_valid    = 4'hF;
        #1;
        chk("rr_pointer_after_id1", 32'(req_ready), 32'h4);
        @(posedge clk);
        #1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_zero("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("grant_req0_after_reset", 32'(req_ready), 32'h1);
        got = 0;
        for (int c = 0; c < 400 && got < 4; c++) begin
            g = req_valid & req_ready;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~g;
            @(negedge clk);
            if (rsp_valid) begin
                chk($sformatf("multi%0d_id", got), 32'(rsp_id), 32'(m_id[got]));
                chk($sformatf("multi%0d_q", got), 32'(rsp_quotient), 32'(m_q[got]));
                chk($sformatf("multi%0d_r", got), 32'(rsp_remainder), 32'(m_r[got]));
                chk($sformatf("multi%0d_status", got), 32'(rsp_status), 0);
                got++;
            end
        end
        chk("multi_rsp_count", 32'(got), 4);

        // Reset during WAIT_DONE abandons the job silently.
        req_valid = '0;
        accept(1, 8'd188, 8'd28, "abort");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        chk("abort_no_rsp", 32'(cnt), 0);
        run_job(2, 215, 19, 11, 6, 0, 9, "after_abort");

        // Divider ready stuck high: timeout, then a normal job.
        stuck = 1'b1;
        run_job(3, 77, 5, 0, 0, 2, TO + 2, "timeout");
        stuck = 1'b0;
        run_job(0, 77, 5, 15, 2, 0, 9, "after_timeout");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
